// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FETCH_STEP = 4;
    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory, downstream handshake and control signals of the fetch sequencer.
interface imem_fetch_ctrl_if;

    logic [31:0] imem_adrs;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_adrs,
        input  imem_data,
        output inst,
        output inst_pc,
        output inst_valid,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output fault,
        output fault_pc
    );

    modport slave (
        input  imem_adrs,
        output imem_data,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output inst_ready,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry fetch FIFO; the head is a register so it holds its last value once drained or flushed.
module fetch_skid_buf
    import imem_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           din,
    output entry_t           head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    entry_t           slot1;
    entry_t           head_n;
    entry_t           slot1_n;
    logic [CNT_W-1:0] count_n;

    // Next head/second slot/occupancy; callers never push into a full buffer without a pop.
    always_comb begin
        head_n  = head;
        slot1_n = slot1;
        count_n = count;
        if (flush) begin
            count_n = '0;
        end else begin
            case (count)
                CNT_W'(0): begin
                    if (push) begin
                        head_n  = din;
                        count_n = CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (push && pop) begin
                        head_n = din;
                    end else if (push) begin
                        slot1_n = din;
                        count_n = CNT_W'(2);
                    end else if (pop) begin
                        count_n = CNT_W'(0);
                    end
                end
                default: begin
                    if (pop) begin
                        head_n = slot1;
                        if (push) begin
                            slot1_n = din;
                        end else begin
                            count_n = CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            slot1 <= '0;
            count <= '0;
            valid <= 1'b0;
        end else begin
            head  <= head_n;
            slot1 <= slot1_n;
            count <= count_n;
            valid <= (count_n != '0);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, range check, redirect/halt/fault FSM in front of a 2-entry buffer.
// Optional IMEM_FETCH_PERF_EN adds saturating fetch and stall counters.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 400,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    state_e           state, state_n;
    logic [31:0]      pc, pc_n;
    logic             fault_q, fault_n;
    logic [31:0]      fault_pc_q, fault_pc_n;
    logic             push, pop, flush;
    logic             free, addr_ok;
    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           din;

    assign pop     = bus.inst_valid && bus.inst_ready;
    assign free    = (count != CNT_W'(BUF_DEPTH)) || pop;
    assign addr_ok = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
    assign din     = '{inst: bus.imem_data, pc: pc};

    // Next-state, PC and fault update; redirect overrides everything but reset.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fault_n    = fault_q;
        fault_pc_n = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush   = 1'b1;
            pc_n    = bus.redirect_pc;
            fault_n = 1'b0;
            state_n = bus.halt ? HALT : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.halt) begin
                        state_n = HALT;
                    end else if (!free) begin
                        state_n = FULL;
                    end else if (!addr_ok) begin
                        fault_n    = 1'b1;
                        fault_pc_n = pc;
                        state_n    = FAULT;
                    end else begin
                        push = 1'b1;
                        pc_n = pc + 32'(FETCH_STEP);
                        if ((count == CNT_W'(BUF_DEPTH - 1)) && !pop) begin
                            state_n = FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.halt) begin
                        state_n = HALT;
                    end else if (pop) begin
                        state_n = FETCH;
                    end
                end
                HALT: begin
                    if (!bus.halt) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            fault_q    <= fault_n;
            fault_pc_q <= fault_pc_n;
        end
    end

    fetch_skid_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .head  (head),
        .valid (bus.inst_valid),
        .count (count)
    );

    assign bus.imem_adrs = pc;
    assign bus.inst      = head.inst;
    assign bus.inst_pc   = head.pc;
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;

`ifdef IMEM_FETCH_PERF_EN
    logic stall;
    assign stall = (state == FULL) || ((state == FETCH) && bus.inst_valid && !bus.inst_ready);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected {inst, pc} stream queued on reset/redirect, checked on each pop.
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [7:0]  mem [0:399];
    entry_t      sb_q [$];
    int unsigned rd_idx;

    imem_fetch_ctrl_if bus ();

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    imem_fetch_ctrl #(
        .MEM_BYTES (400),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian combinational memory model.
    always_comb begin
        bus.imem_data = '0;
        rd_idx        = 0;
        if (bus.imem_adrs <= 32'd396) begin
            rd_idx        = 32'(bus.imem_adrs[8:0]);
            bus.imem_data = {mem[rd_idx], mem[rd_idx+1], mem[rd_idx+2], mem[rd_idx+3]};
        end
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        int unsigned i;
        i = 32'(a[8:0]);
        if (a <= 32'd396) return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [31:0] start, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{inst: memword(start + 32'(4 * i)), pc: start + 32'(4 * i)});
        end
    endtask

    // Consumer side: every accepted instruction must be the next one expected.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                entry_t e;
                e = sb_q.pop_front();
                check("sb_pc", bus.inst_pc, e.pc);
                check("sb_inst", bus.inst, e.inst);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 400; i++) mem[i] = 8'($urandom);
        rst                = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        tick();
        tick();

        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_fault_pc", bus.fault_pc, 32'd0);
        check("rst_adrs", bus.imem_adrs, 32'd0);

        // Streaming from reset: first word valid in cycle 2, then one per cycle.
        sb_restart(32'h0, 16);
        bus.inst_ready = 1'b1;
        rst            = 1'b0;
        tick();
        check("lat_valid", 32'(bus.inst_valid), 32'd1);
        check("lat_pc0", bus.inst_pc, 32'h0);
        tick();
        check("seq_pc4", bus.inst_pc, 32'h4);
        tick();
        check("seq_pc8", bus.inst_pc, 32'h8);
        check("seq_inst8", bus.inst, memword(32'h8));

        // Reset mid-stream, then back-pressure from the start.
        rst            = 1'b1;
        bus.inst_ready = 1'b0;
        tick();
        check("rst2_valid", 32'(bus.inst_valid), 32'd0);
        check("rst2_adrs", bus.imem_adrs, 32'd0);
        sb_restart(32'h0, 16);
        rst = 1'b0;
        repeat (5) tick();
        check("full_adrs", bus.imem_adrs, 32'h8);
        check("full_valid", 32'(bus.inst_valid), 32'd1);
        check("full_head", bus.inst_pc, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
        check("full_perf_fetch", perf_fetch_cnt, 32'd2);
`endif
        bus.inst_ready = 1'b1;
        tick();
        check("full_drain_pc4", bus.inst_pc, 32'h4);
        check("full_drain_adrs", bus.imem_adrs, 32'h8);
        tick();
        tick();

        // Redirect while full with a same-cycle pop.
        bus.inst_ready = 1'b0;
        repeat (3) tick();
        check("pre_redir_valid", 32'(bus.inst_valid), 32'd1);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        sb_restart(32'h40, 16);
        check("redir_flush", 32'(bus.inst_valid), 32'd0);
        check("redir_adrs", bus.imem_adrs, 32'h40);
        tick();
        check("redir_valid", 32'(bus.inst_valid), 32'd1);
        check("redir_pc", bus.inst_pc, 32'h40);

        // Misaligned target faults without pushing.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        sb_q.delete();
        tick();
        check("mis_fault", 32'(bus.fault), 32'd1);
        check("mis_fault_pc", bus.fault_pc, 32'h42);
        check("mis_valid", 32'(bus.inst_valid), 32'd0);
        repeat (3) tick();
        check("mis_hold_adrs", bus.imem_adrs, 32'h42);
        check("mis_sticky", 32'(bus.fault), 32'd1);

        // Out-of-range target; redirect clears the fault first.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd400;
        tick();
        bus.redirect_valid = 1'b0;
        check("oor_clear", 32'(bus.fault), 32'd0);
        tick();
        check("oor_fault", 32'(bus.fault), 32'd1);
        check("oor_fault_pc", bus.fault_pc, 32'd400);

        // Last legal words fetch, the next address faults.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd392;
        tick();
        bus.redirect_valid = 1'b0;
        sb_restart(32'd392, 2);
        check("edge_clear", 32'(bus.fault), 32'd0);
        repeat (3) tick();
        check("edge_fault", 32'(bus.fault), 32'd1);
        check("edge_fault_pc", bus.fault_pc, 32'd400);
        check("edge_valid", 32'(bus.inst_valid), 32'd0);
        check("edge_sb_empty", 32'(sb_q.size()), 32'd0);

        // Recovery redirect.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        tick();
        bus.redirect_valid = 1'b0;
        sb_restart(32'h10, 16);
        check("rec_fault", 32'(bus.fault), 32'd0);
        check("rec_valid0", 32'(bus.inst_valid), 32'd0);
        tick();
        check("rec_valid", 32'(bus.inst_valid), 32'd1);
        check("rec_pc", bus.inst_pc, 32'h10);

        // Halt with one entry buffered: it drains, nothing new is fetched.
        bus.halt       = 1'b1;
        bus.inst_ready = 1'b0;
        tick();
        check("halt_valid", 32'(bus.inst_valid), 32'd1);
        check("halt_head", bus.inst_pc, 32'h10);
        check("halt_adrs", bus.imem_adrs, 32'h14);
        bus.inst_ready = 1'b1;
        tick();
        check("halt_drained", 32'(bus.inst_valid), 32'd0);
        check("halt_hold_pc", bus.inst_pc, 32'h10);
        repeat (3) tick();
        check("halt_idle_valid", 32'(bus.inst_valid), 32'd0);
        check("halt_idle_adrs", bus.imem_adrs, 32'h14);
        bus.halt = 1'b0;
        tick();
        check("resume_valid0", 32'(bus.inst_valid), 32'd0);
        tick();
        check("resume_valid", 32'(bus.inst_valid), 32'd1);
        check("resume_pc", bus.inst_pc, 32'h14);

        // Fill to two entries, then reset.
        bus.inst_ready = 1'b0;
        repeat (2) tick();
        check("prerst_adrs", bus.imem_adrs, 32'h1c);
        rst = 1'b1;
        tick();
        sb_q.delete();
        check("mrst_valid", 32'(bus.inst_valid), 32'd0);
        check("mrst_adrs", bus.imem_adrs, 32'h0);
        check("mrst_fault", 32'(bus.fault), 32'd0);
        check("mrst_inst_pc", bus.inst_pc, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
        check("mrst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("mrst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
